// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and sizes for the common data bus: packet layout seen by the
// reservation station tag CAMs, the PRF and the ROB.
package cdb_broadcaster_pkg;

  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int VALUE_W   = 64;
  localparam int NUM_FU    = 8;   // 3 ALU, 2 MULT, 1 LD, 1 ST, 1 BR
  localparam int SS_SIZE   = 3;

  typedef struct packed {
    logic [PRF_IDX_W-1:0] tag;
    logic [VALUE_W-1:0]   value;
    logic [ROB_IDX_W-1:0] rob_idx;
  } CDB_PKT_T;

  // Physical register 0 is hardwired to zero; nobody waits on its tag.
  function automatic logic is_zero_tag(input CDB_PKT_T pkt);
    return pkt.tag == '0;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_fu_fifo.sv
// Per-FU result FIFO (module cdb_fu_fifo). DEPTH must be a power of 2 so the
// read/write pointers wrap naturally. Storage is not reset; only the
// occupancy count and pointers are.
module cdb_fu_fifo
  import cdb_broadcaster_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     flush,
  input  logic     push,
  input  logic     pop,
  input  CDB_PKT_T pkt_in,
  output CDB_PKT_T head,
  output logic     empty,
  output logic     full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  CDB_PKT_T         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Next pointers and occupancy; flush discards everything buffered.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage write.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= pkt_in;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: buffers FU results per FU and broadcasts up to
// CDB_WIDTH packets per cycle with round-robin fairness across FUs.
// Optional feature macro: CDB_ZERO_TAG_FILTER_EN (drop tag-0 results silently).
module cdb_broadcaster
  import cdb_broadcaster_pkg::CDB_PKT_T;
  import cdb_broadcaster_pkg::SS_SIZE;
#(
  parameter int NUM_FU    = cdb_broadcaster_pkg::NUM_FU,
  parameter int CDB_WIDTH = SS_SIZE,
  parameter int BUF_DEPTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_FU-1:0]       fu_done,
  input  CDB_PKT_T [NUM_FU-1:0]   fu_pkt,
  output logic [NUM_FU-1:0]       fu_stall,
  output logic [CDB_WIDTH-1:0]    CAM_en,
  output CDB_PKT_T [CDB_WIDTH-1:0] CDB_in
);

  localparam int FU_W = $clog2(NUM_FU);

  logic [1:0]                rst_sync_q, rst_sync_d;
  logic                      run, clr;
  logic [NUM_FU-1:0]         fifo_push, fifo_pop, fifo_empty, fifo_full, keep;
  CDB_PKT_T                  fifo_head [NUM_FU];
  logic [FU_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CDB_WIDTH-1:0]      cam_en_q, cam_en_d;
  CDB_PKT_T [CDB_WIDTH-1:0]  cdb_q, cdb_d;
  logic [FU_W:0]             scan;
  logic [FU_W-1:0]           idx, last_idx;
  int                        lane_cnt;

  // Until the synchronized reset release reaches the second flop, the block
  // behaves as if flushed every cycle.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign run        = rst_sync_q[1];
  assign clr        = flush | ~run;

  assign fu_stall = fifo_full;
  assign CAM_en   = cam_en_q;
  assign CDB_in   = cdb_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
`ifdef CDB_ZERO_TAG_FILTER_EN
    assign keep[i] = ~cdb_broadcaster_pkg::is_zero_tag(fu_pkt[i]);
`else
    assign keep[i] = 1'b1;
`endif

    cdb_fu_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .flush  (clr),
      .push   (fifo_push[i]),
      .pop    (fifo_pop[i]),
      .pkt_in (fu_pkt[i]),
      .head   (fifo_head[i]),
      .empty  (fifo_empty[i]),
      .full   (fifo_full[i])
    );
  end

  // Accept a result only when its FIFO was not full at the start of the
  // cycle; a filtered tag-0 result is accepted but never stored.
  always_comb begin
    fifo_push = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fifo_push[i] = fu_done[i] & ~fifo_full[i] & ~clr & keep[i];
    end
  end

  // Round-robin scan from rr_ptr; the k-th non-empty FIFO found drives lane k.
  always_comb begin
    fifo_pop = '0;
    cam_en_d = '0;
    cdb_d    = '0;
    lane_cnt = 0;
    last_idx = rr_ptr_q;
    scan     = '0;
    idx      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, rr_ptr_q} + (FU_W+1)'(k);
      if (scan >= (FU_W+1)'(NUM_FU)) scan = scan - (FU_W+1)'(NUM_FU);
      idx = scan[FU_W-1:0];
      if (!fifo_empty[idx] && (lane_cnt < CDB_WIDTH)) begin
        fifo_pop[idx] = 1'b1;
        for (int l = 0; l < CDB_WIDTH; l++) begin
          if (l == lane_cnt) begin
            cam_en_d[l] = 1'b1;
            cdb_d[l]    = fifo_head[idx];
          end
        end
        lane_cnt = lane_cnt + 1;
        last_idx = idx;
      end
    end
    if (lane_cnt == 0) begin
      rr_ptr_d = rr_ptr_q;
    end else if (last_idx == FU_W'(NUM_FU - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = last_idx + FU_W'(1);
    end
    if (clr) begin
      fifo_pop = '0;
      cam_en_d = '0;
      cdb_d    = '0;
      rr_ptr_d = '0;
    end
  end

  // Reset release synchronizer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  // Arbiter pointer and registered broadcast lanes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      cam_en_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cam_en_q <= cam_en_d;
      cdb_q    <= cdb_d;
    end
  end

endmodule
